// File: rtl/barrett_reduce_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : kyber_arith_pkg
//  Description : Shared Kyber arithmetic constants, coefficient type and the
//                Barrett multiplier derivation used by barrett_reduce_pipe.
//  Contents    : KYBER_Q, BARRETT_SHIFT, COEFF_W, coeff_t, barrett_v()
//  Revision    : 1.0 - initial release
// ============================================================================
package kyber_arith_pkg;

  localparam int KYBER_Q       = 3329;
  localparam int BARRETT_SHIFT = 26;
  localparam int COEFF_W       = 16;

  typedef logic signed [COEFF_W-1:0] coeff_t;

  // V = floor((2^shift + q/2) / q); 20159 for q=3329, shift=26.
  function automatic int barrett_v(input int q, input int shift);
    longint num;
    num = (longint'(1) << shift) + longint'(q / 2);
    return int'(num / longint'(q));
  endfunction

endpackage
`default_nettype wire

// File: rtl/barrett_reduce_pipe_if.sv
`default_nettype none
// ============================================================================
//  Interface   : barrett_reduce_pipe_if
//  Description : Valid/ready beat bus for the Barrett reducer. Carries LANES
//                packed coefficients, a sideband tag and a per-beat mode bit
//                in, and the reduced lanes plus tag out.
//  Modports    : slave  - the reducer (consumes in_*, produces out_*)
//                master - the surrounding logic (produces in_*, consumes out_*)
//  Revision    : 1.0 - initial release
// ============================================================================
interface barrett_reduce_pipe_if
  import kyber_arith_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = COEFF_W,
  parameter int TAG_W = 8
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic [TAG_W-1:0]       in_tag;
  logic                   in_canon;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic [TAG_W-1:0]       out_tag;

  modport slave (
    input  in_valid, in_data, in_tag, in_canon, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_data, in_tag, in_canon, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

endinterface
`default_nettype wire

// File: rtl/barrett_reduce_pipe_lane.sv
`default_nettype none
// ============================================================================
//  Module      : barrett_lane
//  Description : Combinational per-lane Barrett arithmetic, split at the
//                pipeline register boundaries of barrett_reduce_pipe.
//  Ports       : a_i    -> t_o   quotient estimate t = (V*a + 2^(SHIFT-1))>>>SHIFT
//                s1_a_i, s1_t_i -> r_o   centered remainder r = a - t*Q
//                s2_r_i, canon_i -> c_o  canonical correction (r<0 -> r+Q)
//  Config      : BARRETT_CANON_EN adds the correction ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module barrett_lane
  import kyber_arith_pkg::*;
#(
  parameter int Q     = KYBER_Q,
  parameter int WIDTH = COEFF_W,
  parameter int SHIFT = BARRETT_SHIFT,
  parameter int V     = barrett_v(KYBER_Q, BARRETT_SHIFT)
) (
  input  logic signed [WIDTH-1:0] a_i,
  output logic signed [WIDTH-1:0] t_o,
  input  logic signed [WIDTH-1:0] s1_a_i,
  input  logic signed [WIDTH-1:0] s1_t_i,
  output logic signed [WIDTH-1:0] r_o
`ifdef BARRETT_CANON_EN
  ,
  input  logic signed [WIDTH-1:0] s2_r_i,
  input  logic                    canon_i,
  output logic signed [WIDTH-1:0] c_o
`endif
);

  localparam int P_W = WIDTH + SHIFT;
  localparam int R_W = WIDTH + 2;

  localparam logic signed [P_W-1:0] V_EXT = P_W'(V);
  localparam logic signed [P_W-1:0] RND   = P_W'(1) << (SHIFT - 1);
  localparam logic signed [R_W-1:0] Q_R   = R_W'(Q);

  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] p;
  logic signed [R_W-1:0] a_r;
  logic signed [R_W-1:0] tq;

  // Rounded quotient estimate; |t| stays tiny so WIDTH bits are ample.
  always_comb begin
    a_ext = P_W'(a_i);
    p     = a_ext * V_EXT + RND;
    t_o   = WIDTH'(p >>> SHIFT);
  end

  // The two extra bits absorb |t*Q| slightly exceeding the WIDTH range;
  // the true remainder always fits back into WIDTH bits.
  always_comb begin
    a_r = R_W'(s1_a_i);
    tq  = R_W'(s1_t_i) * Q_R;
    r_o = WIDTH'(a_r - tq);
  end

`ifdef BARRETT_CANON_EN
  localparam logic signed [WIDTH-1:0] Q_W = WIDTH'(Q);

  always_comb begin
    c_o = s2_r_i;
    if (canon_i && s2_r_i[WIDTH-1]) begin
      c_o = s2_r_i + Q_W;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/barrett_reduce_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : barrett_reduce_pipe
//  Description : Pipelined multi-lane Barrett reducer with valid/ready
//                handshake and tag passthrough. Reduces LANES signed
//                coefficients per beat modulo Q to the centered (or, when
//                enabled and requested, canonical) representative.
//  Ports       : clk     - clock, rising edge
//                rst     - synchronous active-low reset
//                bus_if  - barrett_reduce_pipe_if.slave (in_valid/in_ready/
//                          in_data/in_tag/in_canon, out_valid/out_ready/
//                          out_data/out_tag)
//  Config      : BARRETT_CANON_EN - adds stage S3 (canonical correction),
//                latency/capacity 3; otherwise latency/capacity 2 and
//                in_canon is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module barrett_reduce_pipe
  import kyber_arith_pkg::*;
#(
  parameter int Q     = KYBER_Q,
  parameter int WIDTH = COEFF_W,
  parameter int SHIFT = BARRETT_SHIFT,
  parameter int LANES = 4,
  parameter int TAG_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  barrett_reduce_pipe_if.slave  bus_if
);

  localparam int V = barrett_v(Q, SHIFT);

  typedef logic [LANES-1:0][WIDTH-1:0] lanes_t;

  lanes_t           t_calc;
  lanes_t           r_calc;

  logic             s1_v_q, s1_v_d;
  lanes_t           s1_a_q, s1_a_d;
  lanes_t           s1_t_q, s1_t_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_v_q, s2_v_d;
  lanes_t           s2_r_q, s2_r_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic             s1_rdy;
  logic             s2_rdy;

`ifdef BARRETT_CANON_EN
  lanes_t           c_calc;
  logic             s1_canon_q, s1_canon_d;
  logic             s2_canon_q, s2_canon_d;
  logic             s3_v_q, s3_v_d;
  lanes_t           s3_r_q, s3_r_d;
  logic [TAG_W-1:0] s3_tag_q, s3_tag_d;
  logic             s3_rdy;
`else
  logic             canon_unused;
  assign canon_unused = bus_if.in_canon;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    barrett_lane #(
      .Q     (Q),
      .WIDTH (WIDTH),
      .SHIFT (SHIFT),
      .V     (V)
    ) u_lane (
      .a_i    (bus_if.in_data[i*WIDTH +: WIDTH]),
      .t_o    (t_calc[i]),
      .s1_a_i (s1_a_q[i]),
      .s1_t_i (s1_t_q[i]),
      .r_o    (r_calc[i])
`ifdef BARRETT_CANON_EN
      ,
      .s2_r_i (s2_r_q[i]),
      .canon_i(s2_canon_q),
      .c_o    (c_calc[i])
`endif
    );
  end

  // Bubble-collapsing ready chain: a stage may load whenever it is empty or
  // its current contents move on this same cycle.
`ifdef BARRETT_CANON_EN
  assign s3_rdy = !s3_v_q | bus_if.out_ready;
  assign s2_rdy = !s2_v_q | s3_rdy;
`else
  assign s2_rdy = !s2_v_q | bus_if.out_ready;
`endif
  assign s1_rdy = !s1_v_q | s2_rdy;

  assign bus_if.in_ready = s1_rdy;

  always_comb begin
    s1_v_d   = s1_v_q;
    s1_a_d   = s1_a_q;
    s1_t_d   = s1_t_q;
    s1_tag_d = s1_tag_q;
    s2_v_d   = s2_v_q;
    s2_r_d   = s2_r_q;
    s2_tag_d = s2_tag_q;
`ifdef BARRETT_CANON_EN
    s1_canon_d = s1_canon_q;
    s2_canon_d = s2_canon_q;
    s3_v_d     = s3_v_q;
    s3_r_d     = s3_r_q;
    s3_tag_d   = s3_tag_q;
`endif

    if (s1_rdy) begin
      s1_v_d = bus_if.in_valid;
      if (bus_if.in_valid) begin
        s1_a_d   = lanes_t'(bus_if.in_data);
        s1_t_d   = t_calc;
        s1_tag_d = bus_if.in_tag;
`ifdef BARRETT_CANON_EN
        s1_canon_d = bus_if.in_canon;
`endif
      end
    end

    if (s2_rdy) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_r_d   = r_calc;
        s2_tag_d = s1_tag_q;
`ifdef BARRETT_CANON_EN
        s2_canon_d = s1_canon_q;
`endif
      end
    end

`ifdef BARRETT_CANON_EN
    if (s3_rdy) begin
      s3_v_d = s2_v_q;
      if (s2_v_q) begin
        s3_r_d   = c_calc;
        s3_tag_d = s2_tag_q;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v_q   <= 1'b0;
      s1_a_q   <= '0;
      s1_t_q   <= '0;
      s1_tag_q <= '0;
      s2_v_q   <= 1'b0;
      s2_r_q   <= '0;
      s2_tag_q <= '0;
`ifdef BARRETT_CANON_EN
      s1_canon_q <= 1'b0;
      s2_canon_q <= 1'b0;
      s3_v_q     <= 1'b0;
      s3_r_q     <= '0;
      s3_tag_q   <= '0;
`endif
    end else begin
      s1_v_q   <= s1_v_d;
      s1_a_q   <= s1_a_d;
      s1_t_q   <= s1_t_d;
      s1_tag_q <= s1_tag_d;
      s2_v_q   <= s2_v_d;
      s2_r_q   <= s2_r_d;
      s2_tag_q <= s2_tag_d;
`ifdef BARRETT_CANON_EN
      s1_canon_q <= s1_canon_d;
      s2_canon_q <= s2_canon_d;
      s3_v_q     <= s3_v_d;
      s3_r_q     <= s3_r_d;
      s3_tag_q   <= s3_tag_d;
`endif
    end
  end

`ifdef BARRETT_CANON_EN
  assign bus_if.out_valid = s3_v_q;
  assign bus_if.out_data  = s3_r_q;
  assign bus_if.out_tag   = s3_tag_q;
`else
  assign bus_if.out_valid = s2_v_q;
  assign bus_if.out_data  = s2_r_q;
  assign bus_if.out_tag   = s2_tag_q;
`endif

endmodule
`default_nettype wire
